// File: rtl/motor_ramp_pkg.sv
// motor_ramp_pkg
//   Shared definitions for the three-level motor soft-start/soft-stop sequencer:
//   state encoding, default dwell counter width and the ramp-up dwell helper.
package motor_ramp_pkg;

  // Default dwell counter width.
  localparam int unsigned CNT_W_DEF = 32'd16;

  // State codes are also exported on state_o, so the values are fixed.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RAMP30 = 3'd1,
    ST_RAMP50 = 3'd2,
    ST_RUN100 = 3'd3,
    ST_DEC50  = 3'd4,
    ST_DEC30  = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  // Ramp-up dwell in cycles: a quarter of the nominal time in fast mode,
  // never shorter than one cycle.
  function automatic int unsigned dwell_up(input int unsigned t, input logic fast);
    int unsigned q;
    q = t >> 2;
    if (fast) begin
      if (q == 32'd0) begin
        dwell_up = 32'd1;
      end else begin
        dwell_up = q;
      end
    end else begin
      dwell_up = t;
    end
  endfunction

endpackage

// File: rtl/motor_ramp_sequencer_timer.sv
// ramp_dwell_timer
//   Down-counting dwell timer. A load presets the count (dwell-1); the count
//   then decrements while dec is high and stops at zero.
//   clk, reset : clock, asynchronous active-high reset (count -> 0)
//   load/value : preset the counter to value on this edge
//   dec        : decrement enable
//   zero       : count is zero (current timed state ends on this edge)
module ramp_dwell_timer
  import motor_ramp_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_r;

  assign zero = (cnt_r == {CNT_W{1'b0}});

  // Dwell counter: load has priority over the decrement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= value;
    end else if (dec && !zero) begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/motor_ramp_sequencer.sv
// motor_ramp_sequencer
//   Soft-start/soft-stop controller for a 30/50/100 % motor drive. A run
//   request ramps 30->50->100 with timed dwells; dropping it ramps down
//   100->50->30->off. A fault latches the drive off until acknowledged, after
//   which run_req must be seen low before a restart is accepted.
//   clk, reset            : clock, asynchronous active-high reset
//   run_req               : 1 = run / ramp up, 0 = stop / ramp down
//   fast                  : fast-start select, sampled when leaving IDLE
//   fault, fault_clr      : drive fault level, single-cycle acknowledge
//   out_30/out_50/out_100 : one-hot drive level (all 0 in IDLE and FAULT)
//   state_o               : current state code
//   running, fault_latched: status for RUN100 / FAULT
module motor_ramp_sequencer
  import motor_ramp_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned T30_CYC = 32'd1000,
  parameter int unsigned T50_CYC = 32'd1000,
  parameter int unsigned TDN_CYC = 32'd500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run_req,
  input  logic       fast,
  input  logic       fault,
  input  logic       fault_clr,
  output logic       out_30,
  output logic       out_50,
  output logic       out_100,
  output logic [2:0] state_o,
  output logic       running,
  output logic       fault_latched
);

  // Timer preload values are dwell-1 so that a timed state lasts dwell cycles.
  localparam logic [CNT_W-1:0] LD30_SLOW_C = CNT_W'(dwell_up(T30_CYC, 1'b0) - 32'd1);
  localparam logic [CNT_W-1:0] LD30_FAST_C = CNT_W'(dwell_up(T30_CYC, 1'b1) - 32'd1);
  localparam logic [CNT_W-1:0] LD50_SLOW_C = CNT_W'(dwell_up(T50_CYC, 1'b0) - 32'd1);
  localparam logic [CNT_W-1:0] LD50_FAST_C = CNT_W'(dwell_up(T50_CYC, 1'b1) - 32'd1);
  localparam logic [CNT_W-1:0] LDDN_C      = CNT_W'(TDN_CYC - 32'd1);

  state_t           state_r;
  state_t           next_state_s;
  logic             armed_r;
  logic             armed_nxt_s;
  logic             fast_lat_r;
  logic             fast_lat_nxt_s;
  logic             fast_sel_s;
  logic [CNT_W-1:0] ld30_s;
  logic [CNT_W-1:0] ld50_s;
  logic             load_s;
  logic [CNT_W-1:0] load_val_s;
  logic             zero_s;
  logic             out_30_r;
  logic             out_50_r;
  logic             out_100_r;
  logic [2:0]       state_o_r;
  logic             running_r;
  logic             fault_latched_r;

  ramp_dwell_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (load_s),
    .value (load_val_s),
    .dec   (1'b1),
    .zero  (zero_s)
  );

  // Fast mode in effect: the live input when leaving IDLE, else the latched copy.
  always_comb begin
    if (state_r == ST_IDLE) begin
      fast_sel_s = fast;
    end else begin
      fast_sel_s = fast_lat_r;
    end
  end

  // Ramp-up preloads for the fast mode in effect.
  always_comb begin
    if (fast_sel_s) begin
      ld30_s = LD30_FAST_C;
      ld50_s = LD50_FAST_C;
    end else begin
      ld30_s = LD30_SLOW_C;
      ld50_s = LD50_SLOW_C;
    end
  end

  // Next-state, timer load and flag update; fault overrides everything.
  always_comb begin
    next_state_s   = state_r;
    armed_nxt_s    = armed_r;
    fast_lat_nxt_s = fast_lat_r;
    load_s         = 1'b0;
    load_val_s     = {CNT_W{1'b0}};
    if (fault) begin
      next_state_s = ST_FAULT;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (run_req && armed_r) begin
            next_state_s   = ST_RAMP30;
            fast_lat_nxt_s = fast;
            load_s         = 1'b1;
            load_val_s     = ld30_s;
          end else if (!run_req) begin
            armed_nxt_s = 1'b1;
          end else begin
            next_state_s = ST_IDLE;
          end
        end
        ST_RAMP30: begin
          if (!run_req) begin
            next_state_s = ST_IDLE;
          end else if (zero_s) begin
            next_state_s = ST_RAMP50;
            load_s       = 1'b1;
            load_val_s   = ld50_s;
          end else begin
            next_state_s = ST_RAMP30;
          end
        end
        ST_RAMP50: begin
          if (!run_req) begin
            next_state_s = ST_DEC30;
            load_s       = 1'b1;
            load_val_s   = LDDN_C;
          end else if (zero_s) begin
            next_state_s = ST_RUN100;
          end else begin
            next_state_s = ST_RAMP50;
          end
        end
        ST_RUN100: begin
          if (!run_req) begin
            next_state_s = ST_DEC50;
            load_s       = 1'b1;
            load_val_s   = LDDN_C;
          end else begin
            next_state_s = ST_RUN100;
          end
        end
        // A renewed run request during ramp-down climbs back with a fresh up-dwell.
        ST_DEC50: begin
          if (run_req) begin
            next_state_s = ST_RAMP50;
            load_s       = 1'b1;
            load_val_s   = ld50_s;
          end else if (zero_s) begin
            next_state_s = ST_DEC30;
            load_s       = 1'b1;
            load_val_s   = LDDN_C;
          end else begin
            next_state_s = ST_DEC50;
          end
        end
        ST_DEC30: begin
          if (run_req) begin
            next_state_s = ST_RAMP30;
            load_s       = 1'b1;
            load_val_s   = ld30_s;
          end else if (zero_s) begin
            next_state_s = ST_IDLE;
          end else begin
            next_state_s = ST_DEC30;
          end
        end
        // Leaving FAULT disarms, so a held run_req cannot restart the motor.
        ST_FAULT: begin
          if (fault_clr) begin
            next_state_s = ST_IDLE;
            armed_nxt_s  = 1'b0;
          end else begin
            next_state_s = ST_FAULT;
          end
        end
        default: begin
          next_state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, flags and outputs; outputs are registered copies decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      armed_r         <= 1'b0;
      fast_lat_r      <= 1'b0;
      out_30_r        <= 1'b0;
      out_50_r        <= 1'b0;
      out_100_r       <= 1'b0;
      state_o_r       <= 3'd0;
      running_r       <= 1'b0;
      fault_latched_r <= 1'b0;
    end else begin
      state_r         <= next_state_s;
      armed_r         <= armed_nxt_s;
      fast_lat_r      <= fast_lat_nxt_s;
      out_30_r        <= (next_state_s == ST_RAMP30) || (next_state_s == ST_DEC30);
      out_50_r        <= (next_state_s == ST_RAMP50) || (next_state_s == ST_DEC50);
      out_100_r       <= (next_state_s == ST_RUN100);
      state_o_r       <= next_state_s;
      running_r       <= (next_state_s == ST_RUN100);
      fault_latched_r <= (next_state_s == ST_FAULT);
    end
  end

  assign out_30        = out_30_r;
  assign out_50        = out_50_r;
  assign out_100       = out_100_r;
  assign state_o       = state_o_r;
  assign running       = running_r;
  assign fault_latched = fault_latched_r;

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// Self-checking bench for motor_ramp_sequencer. Two instances share stimulus:
// dut_a (T30=T50=4, TDN=2) and dut_b (T30=T50=8, TDN=2).
module tb_motor_ramp_sequencer;

  logic clk = 1'b0;
  logic reset, run_req, fast, fault, fault_clr;
  logic a_30, a_50, a_100, a_run, a_flt;
  logic b_30, b_50, b_100, b_run, b_flt;
  logic [2:0] a_st, b_st;
  logic [7:0] a_vec, b_vec;
  int checks = 0;
  int errors = 0;

  // Reference model state: per-instance level, cycles left in the dwell, flags.
  int m_st[2];
  int m_left[2];
  bit m_armed[2];
  bit m_fl[2];
  int p30[2] = '{4, 8};
  int p50[2] = '{4, 8};
  int pdn[2] = '{2, 2};

  always #5 clk = ~clk;

  assign a_vec = {a_30, a_50, a_100, a_run, a_flt, a_st};
  assign b_vec = {b_30, b_50, b_100, b_run, b_flt, b_st};

  motor_ramp_sequencer #(.CNT_W(16), .T30_CYC(4), .T50_CYC(4), .TDN_CYC(2)) dut_a (
    .clk(clk), .reset(reset), .run_req(run_req), .fast(fast), .fault(fault),
    .fault_clr(fault_clr), .out_30(a_30), .out_50(a_50), .out_100(a_100),
    .state_o(a_st), .running(a_run), .fault_latched(a_flt));

  motor_ramp_sequencer #(.CNT_W(16), .T30_CYC(8), .T50_CYC(8), .TDN_CYC(2)) dut_b (
    .clk(clk), .reset(reset), .run_req(run_req), .fast(fast), .fault(fault),
    .fault_clr(fault_clr), .out_30(b_30), .out_50(b_50), .out_100(b_100),
    .state_o(b_st), .running(b_run), .fault_latched(b_flt));

  // Expected output vector for a state code: {o30,o50,o100,running,fault,state}.
  function automatic logic [7:0] exp_vec(input int s);
    logic [2:0] c;
    c = 3'(s);
    return {(s == 1 || s == 5), (s == 2 || s == 4), (s == 3), (s == 3), (s == 6), c};
  endfunction

  function automatic int up_dwell(input int t, input bit f);
    if (!f) return t;
    return (t / 4 < 1) ? 1 : t / 4;
  endfunction

  // One clock edge of the behavioural model for instance i.
  task automatic model_step(input int i, input bit run, input bit fs, input bit flt, input bit clr);
    if (flt) begin
      m_st[i] = 6;
    end else begin
      case (m_st[i])
        0: if (run && m_armed[i]) begin
             m_st[i] = 1; m_fl[i] = fs; m_left[i] = up_dwell(p30[i], fs);
           end else if (!run) m_armed[i] = 1'b1;
        1: if (!run) m_st[i] = 0;
           else if (m_left[i] == 1) begin m_st[i] = 2; m_left[i] = up_dwell(p50[i], m_fl[i]); end
           else m_left[i]--;
        2: if (!run) begin m_st[i] = 5; m_left[i] = pdn[i]; end
           else if (m_left[i] == 1) m_st[i] = 3;
           else m_left[i]--;
        3: if (!run) begin m_st[i] = 4; m_left[i] = pdn[i]; end
        4: if (run) begin m_st[i] = 2; m_left[i] = up_dwell(p50[i], m_fl[i]); end
           else if (m_left[i] == 1) begin m_st[i] = 5; m_left[i] = pdn[i]; end
           else m_left[i]--;
        5: if (run) begin m_st[i] = 1; m_left[i] = up_dwell(p30[i], m_fl[i]); end
           else if (m_left[i] == 1) m_st[i] = 0;
           else m_left[i]--;
        default: if (clr) begin m_st[i] = 0; m_armed[i] = 1'b0; end
      endcase
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reset, then one edge with run_req low so the sequencer is armed.
  task automatic do_reset;
    reset = 1'b1; run_req = 1'b0; fast = 1'b0; fault = 1'b0; fault_clr = 1'b0;
    #7;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    reset = 1'b1; run_req = 1'b1; fast = 1'b0; fault = 1'b0; fault_clr = 1'b0;
    #12;
    checks++;
    if (a_vec !== exp_vec(0)) begin errors++; $display("FAIL reset_hold got %b want %b", a_vec, exp_vec(0)); end
    reset = 1'b0;
    tick(); tick();
    checks++;
    if (a_vec !== exp_vec(0)) begin errors++; $display("FAIL reset_unarmed got %b want %b", a_vec, exp_vec(0)); end
  endtask

  task automatic test_ramp_up;
    int e;
    do_reset();
    run_req = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      e = (k <= 4) ? 1 : (k <= 8) ? 2 : 3;
      checks++;
      if (a_vec !== exp_vec(e)) begin errors++; $display("FAIL ramp_up k=%0d got %b want %b", k, a_vec, exp_vec(e)); end
    end
  endtask

  task automatic test_ramp_down;
    int e;
    run_req = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      e = (k <= 2) ? 4 : (k <= 4) ? 5 : 0;
      checks++;
      if (a_vec !== exp_vec(e)) begin errors++; $display("FAIL ramp_down k=%0d got %b want %b", k, a_vec, exp_vec(e)); end
    end
  endtask

  task automatic test_fast;
    int e;
    do_reset();
    fast = 1'b1; run_req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      fast = 1'($urandom_range(0, 1));
      e = (k <= 2) ? 1 : (k <= 4) ? 2 : 3;
      checks++;
      if (b_vec !== exp_vec(e)) begin errors++; $display("FAIL fast k=%0d got %b want %b", k, b_vec, exp_vec(e)); end
    end
    fast = 1'b0;
  endtask

  task automatic test_reverse;
    int e;
    do_reset();
    run_req = 1'b1;
    repeat (9) tick();
    run_req = 1'b0;
    tick();
    checks++;
    if (a_vec !== exp_vec(4)) begin errors++; $display("FAIL rev_dec50 got %b want %b", a_vec, exp_vec(4)); end
    run_req = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      tick();
      e = (j <= 4) ? 2 : 3;
      checks++;
      if (a_vec !== exp_vec(e)) begin errors++; $display("FAIL rev50 j=%0d got %b want %b", j, a_vec, exp_vec(e)); end
    end
    run_req = 1'b0;
    repeat (3) tick();
    checks++;
    if (a_vec !== exp_vec(5)) begin errors++; $display("FAIL rev_dec30 got %b want %b", a_vec, exp_vec(5)); end
    run_req = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      tick();
      e = (j <= 4) ? 1 : (j <= 8) ? 2 : 3;
      checks++;
      if (a_vec !== exp_vec(e)) begin errors++; $display("FAIL rev30 j=%0d got %b want %b", j, a_vec, exp_vec(e)); end
    end
  endtask

  task automatic test_fault;
    do_reset();
    run_req = 1'b1;
    repeat (5) tick();
    checks++;
    if (a_vec !== exp_vec(2)) begin errors++; $display("FAIL flt_pre got %b want %b", a_vec, exp_vec(2)); end
    fault = 1'b1;
    tick();
    checks++;
    if (a_vec !== exp_vec(6)) begin errors++; $display("FAIL flt_enter got %b want %b", a_vec, exp_vec(6)); end
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    checks++;
    if (a_vec !== exp_vec(6)) begin errors++; $display("FAIL flt_clr_ignored got %b want %b", a_vec, exp_vec(6)); end
    fault = 1'b0;
    tick();
    checks++;
    if (a_vec !== exp_vec(6)) begin errors++; $display("FAIL flt_hold got %b want %b", a_vec, exp_vec(6)); end
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    checks++;
    if (a_vec !== exp_vec(0)) begin errors++; $display("FAIL flt_clear got %b want %b", a_vec, exp_vec(0)); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (a_vec !== exp_vec(0)) begin errors++; $display("FAIL flt_no_restart k=%0d got %b want %b", k, a_vec, exp_vec(0)); end
    end
    run_req = 1'b0;
    tick();
    run_req = 1'b1;
    tick();
    checks++;
    if (a_vec !== exp_vec(1)) begin errors++; $display("FAIL flt_rearm got %b want %b", a_vec, exp_vec(1)); end
    run_req = 1'b0;
    fault = 1'b1;
    tick();
    checks++;
    if (a_vec !== exp_vec(6)) begin errors++; $display("FAIL flt_from_ramp30 got %b want %b", a_vec, exp_vec(6)); end
    fault = 1'b0;
  endtask

  task automatic test_async_reset;
    do_reset();
    run_req = 1'b1;
    tick(); tick();
    checks++;
    if (a_vec !== exp_vec(1)) begin errors++; $display("FAIL arst_pre got %b want %b", a_vec, exp_vec(1)); end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (a_vec !== exp_vec(0)) begin errors++; $display("FAIL arst_immediate got %b want %b", a_vec, exp_vec(0)); end
    #3;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (a_vec !== exp_vec(0)) begin errors++; $display("FAIL arst_no_restart k=%0d got %b want %b", k, a_vec, exp_vec(0)); end
    end
    run_req = 1'b0;
    tick();
    run_req = 1'b1;
    tick();
    checks++;
    if (a_vec !== exp_vec(1)) begin errors++; $display("FAIL arst_rearm got %b want %b", a_vec, exp_vec(1)); end
  endtask

  task automatic test_random;
    reset = 1'b1; run_req = 1'b0; fast = 1'b0; fault = 1'b0; fault_clr = 1'b0;
    #7;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_left[i] = 0; m_armed[i] = 1'b0; m_fl[i] = 1'b0;
    end
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 19) == 0) run_req = ~run_req;
      fast = 1'($urandom_range(0, 1));
      if (fault) fault = ($urandom_range(0, 2) != 0);
      else fault = ($urandom_range(0, 99) == 0);
      fault_clr = ($urandom_range(0, 5) == 0);
      tick();
      for (int i = 0; i < 2; i++) model_step(i, run_req, fast, fault, fault_clr);
      checks++;
      if (a_vec !== exp_vec(m_st[0])) begin errors++; $display("FAIL rand_a n=%0d got %b want %b", n, a_vec, exp_vec(m_st[0])); end
      checks++;
      if (b_vec !== exp_vec(m_st[1])) begin errors++; $display("FAIL rand_b n=%0d got %b want %b", n, b_vec, exp_vec(m_st[1])); end
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_fast();
    test_reverse();
    test_fault();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
